pipeline_hazard_ctrl: RTL and testbench

// Central sequencer for the 5-stage pipeline segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Generates per-segment enable, flush and bubble controls, plus EX-stage operand forwarding selects.
// - Detects load-use hazards and taken-branch flushes.
// - Freezes the pipeline during multi-cycle data-memory accesses, with a timeout and error FSM.
// - Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/hazard_fwd_unit.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and forwarding selects.
package pipeline_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational load-use detection and EX-stage operand forwarding selects.
module hazard_fwd_unit #(
    parameter int REG_AW = pipeline_pkg::REG_AW
) (
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_use_rs2,
    input  logic [REG_AW-1:0]   ex_rs1,
    input  logic [REG_AW-1:0]   ex_rs2,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic                ex_memread,
    input  logic                ex_regwrite,
    input  logic [REG_AW-1:0]   mem_rd,
    input  logic                mem_regwrite,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                wb_regwrite,
    output logic                load_use,
    output pipeline_pkg::fwd_sel_t fwd_a,
    output pipeline_pkg::fwd_sel_t fwd_b
);
    import pipeline_pkg::*;

    // The younger producer (MEM) wins over WB; register 0 gets no special treatment.
    function automatic fwd_sel_t pick_fwd(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_rw,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_rw
    );
        if (m_rw && (m_rd == rs))
            return FWD_EXMEM;
        else if (w_rw && (w_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign load_use = ex_memread & ex_regwrite &
                      ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

    assign fwd_a = pick_fwd(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b = pick_fwd(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the pipeline segment registers: stalls, flushes, memory freeze,
// forwarding selects and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = pipeline_pkg::REG_AW,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic              ex_branch_tk,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    import pipeline_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    fwd_sel_t          fwd_a_sel;
    fwd_sel_t          fwd_b_sel;
    logic              freeze;
    logic              flush_event;

    hazard_fwd_unit #(.REG_AW(REG_AW)) u_hazard_fwd (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .load_use     (load_use),
        .fwd_a        (fwd_a_sel),
        .fwd_b        (fwd_b_sel)
    );

    // Mealy priority mux: freeze > taken branch > load-use > normal; everything quiet under reset.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;
        freeze       = 1'b0;
        flush_event  = 1'b0;
        if (!rst) begin
            fwd_a  = fwd_a_sel;
            fwd_b  = fwd_b_sel;
            freeze = ((state == RUN) && mem_req && !mem_ready) ||
                     ((state == WAIT) && !mem_ready);
            if (state == ERR) begin
                // Let the pipeline advance but drop the load data that never arrived.
                pc_en        = 1'b1;
                ifid_en      = 1'b1;
                idex_en      = 1'b1;
                exmem_en     = 1'b1;
                memwb_bubble = 1'b1;
            end else if (freeze) begin
                memwb_bubble = 1'b1;
            end else if (ex_branch_tk) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                flush_event = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ready)
                        state <= RUN;
                    else if (wait_cnt == WAIT_LAST)
                        state <= ERR;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                ERR: begin
                    state   <= RUN;
                    mem_err <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Performance counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_event && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (short timeout and narrow counters).
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW      = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic              id_use_rs2, ex_memread, ex_regwrite, ex_branch_tk;
    logic              mem_regwrite, mem_req, mem_ready, wb_regwrite;
    logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
    logic [1:0]        fwd_a, fwd_b;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_branch_tk (ex_branch_tk),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_bubble (memwb_bubble),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Quiescent inputs: all register numbers distinct, no hazards, no memory traffic.
    task automatic applyStimulus();
        id_rs1       = 4'd1;
        id_rs2       = 4'd2;
        id_use_rs2   = 1'b0;
        ex_rs1       = 4'd6;
        ex_rs2       = 4'd7;
        ex_rd        = 4'd8;
        ex_memread   = 1'b0;
        ex_regwrite  = 1'b0;
        ex_branch_tk = 1'b0;
        mem_rd       = 4'd9;
        mem_regwrite = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
        wb_rd        = 4'd10;
        wb_regwrite  = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic setLoadUse();
        ex_memread  = 1'b1;
        ex_regwrite = 1'b1;
        ex_rd       = 4'd3;
        id_rs1      = 4'd3;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus();
        setLoadUse();
        mem_rd = 4'd6; mem_regwrite = 1'b1;
        #2;
        checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
        checkOutput("rst_exmem_en", 32'(exmem_en), 32'd0);
        checkOutput("rst_idex_flush", 32'(idex_flush), 32'd0);
        checkOutput("rst_fwd_a", 32'(fwd_a), 32'd0);
        doReset();
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
        checkOutput("idle_pc_en", 32'(pc_en), 32'd1);
        checkOutput("idle_bubble", 32'(memwb_bubble), 32'd0);

        // Load-use on rs1, held for exactly one cycle.
        setLoadUse();
        #1;
        checkOutput("lu_pc_en", 32'(pc_en), 32'd0);
        checkOutput("lu_ifid_en", 32'(ifid_en), 32'd0);
        checkOutput("lu_idex_flush", 32'(idex_flush), 32'd1);
        checkOutput("lu_exmem_en", 32'(exmem_en), 32'd1);
        nextCycle();
        applyStimulus();
        #1;
        checkOutput("lu_release_pc_en", 32'(pc_en), 32'd1);
        checkOutput("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // rs2 matches only count when the instruction actually reads rs2.
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 4'd2;
        #1;
        checkOutput("lu_rs2_unused", 32'(pc_en), 32'd1);
        id_use_rs2 = 1'b1;
        #1;
        checkOutput("lu_rs2_used", 32'(pc_en), 32'd0);
        ex_regwrite = 1'b0;
        #1;
        checkOutput("lu_no_regwrite", 32'(pc_en), 32'd1);
        applyStimulus();

        // Forwarding priority and register 0.
        mem_rd = 4'd5; wb_rd = 4'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs1 = 4'd5;
        #1;
        checkOutput("fwd_a_mem", 32'(fwd_a), 32'd1);
        checkOutput("fwd_b_none", 32'(fwd_b), 32'd0);
        mem_regwrite = 1'b0;
        #1;
        checkOutput("fwd_a_wb", 32'(fwd_a), 32'd2);
        ex_rs2 = 4'd5;
        #1;
        checkOutput("fwd_b_wb", 32'(fwd_b), 32'd2);
        wb_regwrite = 1'b0;
        #1;
        checkOutput("fwd_a_off", 32'(fwd_a), 32'd0);
        mem_rd = 4'd0; ex_rs2 = 4'd0; mem_regwrite = 1'b1;
        #1;
        checkOutput("fwd_b_r0", 32'(fwd_b), 32'd1);
        applyStimulus();

        // Taken branch beats a simultaneous load-use.
        doReset();
        setLoadUse();
        ex_branch_tk = 1'b1;
        #1;
        checkOutput("br_pc_en", 32'(pc_en), 32'd1);
        checkOutput("br_ifid_flush", 32'(ifid_flush), 32'd1);
        checkOutput("br_idex_flush", 32'(idex_flush), 32'd1);
        checkOutput("br_ifid_en", 32'(ifid_en), 32'd1);
        nextCycle();
        applyStimulus();
        #1;
        checkOutput("br_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory wait: three frozen cycles, released on the ready cycle; branch suppressed while frozen.
        doReset();
        mem_req = 1'b1; ex_branch_tk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("mw_pc_en_%0d", i), 32'(pc_en), 32'd0);
            checkOutput($sformatf("mw_bubble_%0d", i), 32'(memwb_bubble), 32'd1);
            checkOutput($sformatf("mw_ifid_flush_%0d", i), 32'(ifid_flush), 32'd0);
            checkOutput($sformatf("mw_exmem_en_%0d", i), 32'(exmem_en), 32'd0);
            nextCycle();
        end
        ex_branch_tk = 1'b0; mem_ready = 1'b1;
        #1;
        checkOutput("mw_release_pc_en", 32'(pc_en), 32'd1);
        checkOutput("mw_release_bubble", 32'(memwb_bubble), 32'd0);
        nextCycle();
        applyStimulus();
        #1;
        checkOutput("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        checkOutput("mw_flush_cnt", 32'(flush_cnt), 32'd0);
        checkOutput("mw_mem_err", 32'(mem_err), 32'd0);

        // Timeout: one RUN freeze cycle plus MEM_TIMEOUT WAIT cycles, then a single ERR cycle.
        doReset();
        mem_req = 1'b1;
        for (int i = 0; i < 1 + MEM_TIMEOUT; i++) begin
            #1;
            checkOutput($sformatf("to_freeze_%0d", i), 32'(pc_en), 32'd0);
            nextCycle();
        end
        #1;
        checkOutput("to_err_pc_en", 32'(pc_en), 32'd1);
        checkOutput("to_err_exmem_en", 32'(exmem_en), 32'd1);
        checkOutput("to_err_bubble", 32'(memwb_bubble), 32'd1);
        nextCycle();
        checkOutput("to_refreeze_pc_en", 32'(pc_en), 32'd0);
        checkOutput("to_mem_err_set", 32'(mem_err), 32'd1);
        nextCycle();
        mem_ready = 1'b1;
        #1;
        checkOutput("to_release_pc_en", 32'(pc_en), 32'd1);
        nextCycle();
        applyStimulus();
        #1;
        checkOutput("to_mem_err_sticky", 32'(mem_err), 32'd1);
        checkOutput("to_stall_cnt", 32'(stall_cnt), 32'd6);

        // Reset in the middle of a wait: back to RUN with nothing recorded.
        mem_req = 1'b1;
        nextCycle();
        nextCycle();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rw_rst_bubble", 32'(memwb_bubble), 32'd0);
        checkOutput("rw_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rw_rst_mem_err", 32'(mem_err), 32'd0);
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("rw_run_pc_en", 32'(pc_en), 32'd1);
        for (int i = 0; i < MEM_TIMEOUT + 2; i++) nextCycle();
        checkOutput("rw_no_err", 32'(mem_err), 32'd0);
        checkOutput("rw_bubble", 32'(memwb_bubble), 32'd0);
        checkOutput("rw_stall_cnt", 32'(stall_cnt), 32'd0);

        // Saturation of both counters at all-ones.
        doReset();
        setLoadUse();
        for (int i = 0; i < 10; i++) nextCycle();
        checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd7);
        applyStimulus();
        ex_branch_tk = 1'b1;
        for (int i = 0; i < 10; i++) nextCycle();
        checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'd7);
        checkOutput("sat_stall_hold", 32'(stall_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
